serial_rx: RTL

SERIAL_RX -- requirements
Module: serial_rx

---
 rtl/serial_rx.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/serial_rx.sv
// serial_rx: asynchronous 8N1 serial receiver with baud select,
// single-byte holding register, overrun flag and framing-error pulse.
//
// Ports:
//   clk       - system clock, all state changes on its rising edge
//   reset     - asynchronous active-low reset
//   mode[1:0] - baud select, bit period T = DIV << mode clocks
//   Rxd       - asynchronous serial line, idles high
//   ack       - consumer acknowledge for the held byte
//   dat[7:0]  - last correctly framed received byte
//   valid     - dat holds an unacknowledged byte
//   overrun   - sticky, a new byte overwrote an unacknowledged one
//   frame_err - one-cycle pulse when the sampled stop bit is 0
module serial_rx #(
    parameter int DIV = 1302
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] mode,
    input  logic       Rxd,
    input  logic       ack,
    output logic [7:0] dat,
    output logic       valid,
    output logic       overrun,
    output logic       frame_err
);

    localparam int TW_MIN = $clog2(DIV * 8 + 1);
    localparam int TW     = (TW_MIN > 15) ? TW_MIN : 15;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [2:0]    idx_q, idx_d;
    logic [1:0]    mode_lat_q, mode_lat_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    dat_q, dat_d;
    logic          valid_q, valid_d;
    logic          overrun_q, overrun_d;
    logic          frame_err_q, frame_err_d;
    logic          rs1_q, rs1_d;
    logic          rs_q, rs_d;
    logic          rs_prev_q, rs_prev_d;

    logic [TW-1:0] t_full;
    logic [TW-1:0] t_half_new;
    logic          good_stop;

    // Full period uses the mode latched at the start edge; the half
    // period is loaded on that same edge, so it uses the live input.
    assign t_full     = TW'(DIV) << mode_lat_q;
    assign t_half_new = (TW'(DIV) << mode) >> 1;

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        idx_d       = idx_q;
        mode_lat_d  = mode_lat_q;
        shift_d     = shift_q;
        dat_d       = dat_q;
        valid_d     = valid_q;
        overrun_d   = overrun_q;
        frame_err_d = 1'b0;
        good_stop   = 1'b0;
        rs1_d       = Rxd;
        rs_d        = rs1_q;
        rs_prev_d   = rs_q;

        case (state_q)
            S_IDLE: begin
                // Needs a true 1->0 transition; a line stuck low
                // after a bad stop bit never retriggers.
                if (rs_prev_q && !rs_q) begin
                    mode_lat_d = mode;
                    timer_d    = t_half_new - TW'(1);
                    state_d    = S_START;
                end
            end
            S_START: begin
                if (timer_q != '0) begin
                    timer_d = timer_q - TW'(1);
                end else if (!rs_q) begin
                    timer_d = t_full - TW'(1);
                    idx_d   = 3'd0;
                    state_d = S_DATA;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_DATA: begin
                if (timer_q != '0) begin
                    timer_d = timer_q - TW'(1);
                end else begin
                    shift_d = {rs_q, shift_q[7:1]};
                    timer_d = t_full - TW'(1);
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end
                end
            end
            default: begin
                if (timer_q != '0) begin
                    timer_d = timer_q - TW'(1);
                end else begin
                    state_d = S_IDLE;
                    if (rs_q) begin
                        good_stop = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
            end
        endcase

        // A new byte with a pending unacked one sets overrun; an ack
        // in the same cycle consumes the old byte, so no overrun.
        if (good_stop) begin
            dat_d     = shift_q;
            valid_d   = 1'b1;
            overrun_d = valid_q ? !ack : overrun_q;
        end else if (ack && valid_q) begin
            valid_d   = 1'b0;
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            timer_q     <= '0;
            idx_q       <= 3'd0;
            mode_lat_q  <= 2'd0;
            shift_q     <= 8'h00;
            dat_q       <= 8'h00;
            valid_q     <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
            rs1_q       <= 1'b1;
            rs_q        <= 1'b1;
            rs_prev_q   <= 1'b1;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            idx_q       <= idx_d;
            mode_lat_q  <= mode_lat_d;
            shift_q     <= shift_d;
            dat_q       <= dat_d;
            valid_q     <= valid_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
            rs1_q       <= rs1_d;
            rs_q        <= rs_d;
            rs_prev_q   <= rs_prev_d;
        end
    end

    assign dat       = dat_q;
    assign valid     = valid_q;
    assign overrun   = overrun_q;
    assign frame_err = frame_err_q;

endmodule
